// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: default 640x480@60 modes, sync polarities,
// and the per-axis timing-mode struct used to configure each axis counter.
package vga_pkg;

  // One axis of raster timing, in pixels (horizontal) or lines (vertical).
  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } timing_mode_t;

  localparam logic POL_NEG = 1'b0;
  localparam logic POL_POS = 1'b1;

  localparam timing_mode_t VGA_640X480_H = '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48};
  localparam timing_mode_t VGA_640X480_V = '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33};

  // Full period of one axis: active, front porch, sync and back porch.
  function automatic int mode_total(input timing_mode_t m);
    return int'(m.active) + int'(m.fp) + int'(m.sync) + int'(m.bp);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with active-region and
// sync-pulse decode. Used once per line (horizontal) and once per frame
// (vertical, enabled by the horizontal wrap).
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int           CNT_W = 11,
  parameter timing_mode_t MODE  = VGA_640X480_H
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             active,
  output logic             sync
);

  localparam int               TOTAL    = mode_total(MODE);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  // Decode bounds are one bit wider so an end point equal to 2^CNT_W still compares correctly.
  localparam logic [CNT_W:0]   ACT_END  = (CNT_W+1)'(int'(MODE.active));
  localparam logic [CNT_W:0]   SYNC_LO  = (CNT_W+1)'(int'(MODE.active) + int'(MODE.fp));
  localparam logic [CNT_W:0]   SYNC_HI  = (CNT_W+1)'(int'(MODE.active) + int'(MODE.fp) + int'(MODE.sync));

  assign wrap   = en && (cnt == LAST);
  assign active = {1'b0, cnt} < ACT_END;
  assign sync   = ({1'b0, cnt} >= SYNC_LO) && ({1'b0, cnt} < SYNC_HI);

  // Position counter: step on enable, return to 0 after the last position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. Divides clk down to a pixel
// strobe, runs horizontal/vertical axis counters, registers sync/de/coords
// one pixel behind the counters, and blanks the renderer colour outside
// the visible region.
// Optional build macro VGA_TESTPATTERN_EN adds input tp_sel, which replaces
// the renderer colour with eight vertical colour bars.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV  = 2,
  parameter int   COLOR_W  = 1,
  parameter int   CNT_W    = 11,
  parameter int   H_ACTIVE = int'(VGA_640X480_H.active),
  parameter int   H_FP     = int'(VGA_640X480_H.fp),
  parameter int   H_SYNC   = int'(VGA_640X480_H.sync),
  parameter int   H_BP     = int'(VGA_640X480_H.bp),
  parameter int   V_ACTIVE = int'(VGA_640X480_V.active),
  parameter int   V_FP     = int'(VGA_640X480_V.fp),
  parameter int   V_SYNC   = int'(VGA_640X480_V.sync),
  parameter int   V_BP     = int'(VGA_640X480_V.bp),
  parameter logic HS_POL   = POL_NEG,
  parameter logic VS_POL   = POL_NEG
) (
  input  logic               clk,
  input  logic               rst,
`ifdef VGA_TESTPATTERN_EN
  input  logic               tp_sel,
`endif
  input  logic [COLOR_W-1:0] pix_r,
  input  logic [COLOR_W-1:0] pix_g,
  input  logic [COLOR_W-1:0] pix_b,
  output logic               pix_ce,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [CNT_W-1:0]   x_pos,
  output logic [CNT_W-1:0]   y_pos,
  output logic               line_start,
  output logic               frame_start,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b
);

  localparam timing_mode_t H_MODE = '{active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)};
  localparam timing_mode_t V_MODE = '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)};

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] divider;
  logic [DIV_W-1:0] divider_nxt;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, v_wrap;
  logic             h_active, v_active;
  logic             h_sync, v_sync;
  logic             at_origin;

  assign divider_nxt = (divider == DIV_LAST) ? '0 : divider + DIV_W'(1);

  // Clock divider; pix_ce is registered so it is high exactly while divider == CLK_DIV-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divider <= '0;
      pix_ce  <= 1'b0;
    end else begin
      divider <= divider_nxt;
      pix_ce  <= (divider_nxt == DIV_LAST);
    end
  end

  vga_axis_counter #(.CNT_W(CNT_W), .MODE(H_MODE)) u_h_axis (
    .clk    (clk),
    .rst    (rst),
    .en     (pix_ce),
    .cnt    (h_cnt),
    .wrap   (h_wrap),
    .active (h_active),
    .sync   (h_sync)
  );

  vga_axis_counter #(.CNT_W(CNT_W), .MODE(V_MODE)) u_v_axis (
    .clk    (clk),
    .rst    (rst),
    .en     (h_wrap),
    .cnt    (v_cnt),
    .wrap   (v_wrap),
    .active (v_active),
    .sync   (v_sync)
  );

  // Tracks that the counters sit at (0,0): true out of reset and after each full-frame wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      at_origin <= 1'b1;
    end else if (pix_ce) begin
      at_origin <= v_wrap;
    end
  end

  // Pixel-aligned outputs, registered from the counters one pixel behind them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_ce && (h_cnt == '0) && v_active;
      frame_start <= pix_ce && at_origin;
      if (pix_ce) begin
        hsync <= h_sync ? HS_POL : ~HS_POL;
        vsync <= v_sync ? VS_POL : ~VS_POL;
        de    <= h_active && v_active;
        if (h_active && v_active) begin
          x_pos <= h_cnt;
          y_pos <= v_cnt;
        end
      end
    end
  end

`ifdef VGA_TESTPATTERN_EN
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);

  logic [2:0]       bar_idx;
  logic [CNT_W-1:0] bar_px;

  // Bar index follows x_pos: cleared with the first pixel of a line, stepped every H_ACTIVE/8 pixels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bar_idx <= '0;
      bar_px  <= '0;
    end else if (pix_ce && h_active) begin
      if (h_cnt == '0) begin
        bar_idx <= '0;
        bar_px  <= '0;
      end else if (bar_px == BAR_LAST) begin
        bar_idx <= bar_idx + 3'd1;
        bar_px  <= '0;
      end else begin
        bar_px  <= bar_px + CNT_W'(1);
      end
    end
  end

  // Colour select and blanking: bars or renderer colour inside the visible region, black elsewhere.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    vga_r = '0;
    vga_g = '0;
    vga_b = '0;
    if (de) begin
      if (tp_sel) begin
        vga_r = {COLOR_W{bar_idx[2]}};
        vga_g = {COLOR_W{bar_idx[1]}};
        vga_b = {COLOR_W{bar_idx[0]}};
      end else begin
        vga_r = pix_r;
        vga_g = pix_g;
        vga_b = pix_b;
      end
    end
  end
`else
  // Blanking: renderer colour passes only inside the visible region.
  always_comb begin
    vga_r = de ? pix_r : '0;
    vga_g = de ? pix_g : '0;
    vga_b = de ? pix_b : '0;
  end
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator, the successor to the fixed 640x480 generator.
- Sync porches, polarities, pixel-clock divide and colour depth are all parameters.
- Emits a registered display-enable, pixel coordinates, and frame/line strobes.
- Sits between the system clock domain and the VGA DAC pins. The game renderer reads x_pos/y_pos and returns colour on pix_r/g/b.

Parameters:
CLK_DIV, 2, system clocks per pixel (>=1; 1 = pixel clock equals clk)
COLOR_W, 1, bits per colour channel
CNT_W, 11, counter/coordinate width; H_TOTAL and V_TOTAL must each be <= 2^CNT_W
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level
VS_POL, 0, vsync active level

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
pix_r  in  COLOR_W  renderer red for current x_pos/y_pos
pix_g  in  COLOR_W  renderer green
pix_b  in  COLOR_W  renderer blue
pix_ce  out  1  one-clk pixel strobe
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
de  out  1  display enable (visible region)
x_pos  out  CNT_W  column; valid only while de=1
y_pos  out  CNT_W  row; valid only while de=1
line_start  out  1  one-clk pulse at first visible pixel of each line
frame_start  out  1  one-clk pulse at pixel (0,0)
vga_r  out  COLOR_W  blanked red to DAC
vga_g  out  COLOR_W  blanked green to DAC
vga_b  out  COLOR_W  blanked blue to DAC

Behaviour:
Clock and reset:
- Single clock, clk. Reset rst is asynchronous and active-low.
- During reset: divider=0, h_cnt=0, v_cnt=0, pix_ce=0, de=0, x_pos=0, y_pos=0, line_start=0, frame_start=0, hsync=~HS_POL, vsync=~VS_POL.

Pixel strobe:
- Divider counts 0..CLK_DIV-1. pix_ce=1 for the single clk cycle in which divider==CLK_DIV-1.
- With CLK_DIV=1, pix_ce is 1 in every cycle after reset.

Counters (advance only when pix_ce=1):
- h_cnt counts 0..H_TOTAL-1, then wraps to 0. H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
- v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1 on that same edge. V_TOTAL is defined analogously.

Line ordering:
- Active first, then front porch, sync, back porch.
- hsync is active while h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vsync is active while v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).

Registered outputs:
- hsync, vsync, de, x_pos and y_pos are registered on pix_ce from the current counter values. They are mutually aligned and lag the counters by one pixel.
- x_pos/y_pos hold their last value while de=0.

Colour path:
- vga_* = de ? pix_* : 0 (combinational gating). The renderer must produce pix_* combinationally from x_pos/y_pos.
- Output is zero throughout blanking, unlike the ungated predecessor.

Strobes:
- line_start goes high for exactly one clk cycle, the cycle after the pix_ce edge that loads x_pos=0 with de=1.
- frame_start is the same pulse when additionally y_pos=0. It coincides with line_start for line 0.

Reset mid-frame: all state returns to reset values immediately; after release the raster restarts at (0,0).

Optional Feature:
VGA_TESTPATTERN_EN
- With the macro: an extra input tp_sel (1 bit) is present. When tp_sel=1, pix_* are ignored and the output is 8 vertical colour bars, each H_ACTIVE/8 pixels wide.
  - A bar index counter resets at line_start and advances every H_ACTIVE/8 visible pixels.
  - Bar k drives vga_r = {COLOR_W{k[2]}}, vga_g = {COLOR_W{k[1]}}, vga_b = {COLOR_W{k[0]}}. Blanking still applies.
- Without the macro: no tp_sel port and no bar logic.

Decomposition:
- Package vga_pkg: default 640x480@60 timing constants, polarity constants, and a timing-mode struct typedef {active, fp, sync, bp}.
- Sub-module vga_axis_counter: counter with wrap, active and sync decode. Instantiated twice (horizontal, vertical), with the vertical instance enabled by the horizontal wrap.

Test Plan:
- Default params, rst released: pix_ce every 2nd clk. hsync low for 96 pixels starting at h_cnt=656. Line period 1600 clk. Frame period 525 lines (840000 clk).
- vsync active for exactly 2 lines beginning at line 490. de high for 640x480 pixels per frame. frame_start pulses once per frame with x_pos=0, y_pos=0.
- pix_r=1 held constant: vga_r=1 only while de=1 and 0 in all porches and sync. x_pos sweeps 0..639 and y_pos sweeps 0..479.
- CLK_DIV=1, HS_POL=1, H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V tiny: hsync high for h_cnt 10..11. Wrap at 13->0 and v wrap are both verified in the same pix_ce.
- Assert rst mid-line at h_cnt=300: all outputs take reset values within the same cycle. After release, first de occurs 1 pixel later with x_pos=0, y_pos=0.
- VGA_TESTPATTERN_EN, tp_sel=1: x_pos 0..79 gives rgb=000, x_pos 80..159 gives 001, and so on up to x_pos 560..639 giving 111.
